// File: rtl/quad_encoder_emulator.sv
// Quadrature (A/B) encoder waveform generator for encoder-receiver bring-up.
// Emits bursts of N transitions (or runs continuously) at a programmable step period.
module quad_encoder_emulator #(
  parameter int PERIOD_W = 16,
  parameter int COUNT_W  = 16
) (
  input  logic                clk_sys,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic                dir,
  input  logic [PERIOD_W-1:0] step_period,
  input  logic [COUNT_W-1:0]  n_edges,
  output logic                a_out,
  output logic                b_out,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [COUNT_W-1:0]  edge_count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic                dir_q;
  logic [PERIOD_W-1:0] per_q;
  logic [PERIOD_W-1:0] cnt_q;
  logic [COUNT_W-1:0]  n_q;
  logic [PERIOD_W-1:0] per_eff;
  logic                accept, fire, emit, complete, terminal, abort;
  logic                step_dir;

  assign per_eff  = (step_period == '0) ? PERIOD_W'(1) : step_period;
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign step_dir = accept ? dir : dir_q;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // The counter runs one cycle ahead so the k-th transition lands at T+k*P;
  // with P=1 the first transition is therefore emitted on the accepting edge.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    fire     = 1'b0;
    emit     = 1'b0;
    complete = 1'b0;
    terminal = 1'b0;
    abort    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          accept  = 1'b1;
          emit    = (per_eff == PERIOD_W'(1));
          state_d = RUN;
        end
      end
      RUN: begin
        complete = (n_q != '0) && (edge_count == n_q);
        fire     = (cnt_q == per_q - PERIOD_W'(1));
        terminal = fire && (n_q != '0) && ((edge_count + COUNT_W'(1)) == n_q);
        if (complete) begin
          state_d = DONE;
        end else if (stop && !terminal) begin
          abort   = 1'b1;
          state_d = DONE;
        end else begin
          // A stop coinciding with the terminal step lets it finish as a normal completion.
          emit = fire;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      dir_q      <= 1'b0;
      per_q      <= '0;
      n_q        <= '0;
      cnt_q      <= '0;
      aborted    <= 1'b0;
      edge_count <= '0;
      a_out      <= 1'b0;
      b_out      <= 1'b0;
    end else begin
      if (accept) begin
        dir_q   <= dir;
        per_q   <= per_eff;
        n_q     <= n_edges;
        aborted <= 1'b0;
        cnt_q   <= (per_eff == PERIOD_W'(1)) ? '0 : PERIOD_W'(1);
      end else if (state_q == RUN && !complete) begin
        cnt_q <= fire ? '0 : cnt_q + PERIOD_W'(1);
      end
      if (abort) aborted <= 1'b1;
      if (emit) begin
        edge_count <= accept ? COUNT_W'(1) : edge_count + COUNT_W'(1);
        if (step_dir) begin
          a_out <= ~b_out;
          b_out <= a_out;
        end else begin
          a_out <= b_out;
          b_out <= ~a_out;
        end
      end else if (accept) begin
        edge_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Scoreboard bench: bursts queue expected transitions/done events, a negedge monitor checks them.
module tb_quad_encoder_emulator;
  localparam int PW = 16;
  localparam int CW = 16;
  localparam int FAR = 32'h7fff_ffff;

  logic          clk_sys = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          dir = 1'b0;
  logic [PW-1:0] step_period = '0;
  logic [CW-1:0] n_edges = '0;
  logic          a_out, b_out, busy, done, aborted;
  logic [CW-1:0] edge_count;

  quad_encoder_emulator #(.PERIOD_W(PW), .COUNT_W(CW)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .start(start), .stop(stop), .dir(dir),
    .step_period(step_period), .n_edges(n_edges), .a_out(a_out), .b_out(b_out),
    .busy(busy), .done(done), .aborted(aborted), .edge_count(edge_count)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  typedef struct {
    bit            is_done;
    int            cyc;
    logic          a, b, ab;
    logic [CW-1:0] cnt;
  } ev_t;

  ev_t           expq[$];
  ev_t           me;
  int            total = 0, bad = 0;
  int            run_lo = 1, run_hi = 0;
  int            b_t1 = 0, b_done = FAR;
  bit            b_ab = 0, prev_ab = 0;
  bit            mon_en = 0;
  logic [1:0]    prev_ph = 2'b00;
  logic [CW-1:0] last_cnt = '0;
  // Reference phase: index into the forward (A,B) sequence, reverse walks it backwards.
  logic [1:0]    seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  int            mi = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk_sys) begin
    if (!rst_n) begin
      prev_ph = 2'b00;
    end else if (mon_en) begin
      chk("busy", busy, (cyc >= run_lo && cyc <= run_hi));
      chk("aborted", aborted, (cyc < b_t1) ? prev_ab : ((cyc >= b_done) ? b_ab : 1'b0));
      if ({a_out, b_out} != prev_ph) begin
        if (expq.size() == 0) chk("spurious_trans", expq.size(), 1);
        else begin
          me = expq.pop_front();
          chk("trans_kind", me.is_done, 0);
          chk("trans", {cyc, a_out, b_out, edge_count}, {me.cyc, me.a, me.b, me.cnt});
        end
      end
      if (done) begin
        if (expq.size() == 0) chk("spurious_done", expq.size(), 1);
        else begin
          me = expq.pop_front();
          chk("done_kind", me.is_done, 1);
          chk("done", {cyc, a_out, b_out, aborted, busy, edge_count},
                      {me.cyc, me.a, me.b, me.ab, 1'b0, me.cnt});
        end
      end
      prev_ph = {a_out, b_out};
    end
  end

  task automatic burst(input bit d, input int p, input int n, input int so, input bit busy_start);
    int peff, t0, s, jmax, dc, sb;
    bit ab;
    ev_t e;
    logic [31:0] r;
    peff = (p == 0) ? 1 : p;
    @(posedge clk_sys); #1;
    dir = d; step_period = p[PW-1:0]; n_edges = n[CW-1:0]; start = 1'b1; stop = 1'b0;
    t0 = cyc;
    s  = t0 + so;
    if (n != 0 && (so == 0 || s >= t0 + n * peff - 1)) begin
      jmax = n; dc = t0 + n * peff + 1; ab = 1'b0;
    end else begin
      jmax = (s - t0) / peff; dc = s + 1; ab = 1'b1;
    end
    for (int j = 1; j <= jmax; j++) begin
      mi = d ? (mi + 1) % 4 : (mi + 3) % 4;
      e.is_done = 1'b0; e.cyc = t0 + j * peff;
      {e.a, e.b} = seq[mi]; e.ab = 1'b0; e.cnt = j[CW-1:0];
      expq.push_back(e);
    end
    e.is_done = 1'b1; e.cyc = dc; {e.a, e.b} = seq[mi]; e.ab = ab; e.cnt = jmax[CW-1:0];
    expq.push_back(e);
    last_cnt = jmax[CW-1:0];
    prev_ab = b_ab; b_t1 = t0 + 1; b_done = dc; b_ab = ab;
    run_lo = t0 + 1; run_hi = dc - 1;
    sb = busy_start ? int'($urandom_range(1, dc - t0)) : 0;
    while (cyc < dc + 2) begin
      @(posedge clk_sys); #1;
      start = (sb != 0 && cyc == t0 + sb);
      stop  = (so != 0 && cyc == s);
      r = $urandom;
      dir = r[0]; step_period = r[PW-1:0]; n_edges = r[31:32-CW];
    end
    start = 1'b0; stop = 1'b0;
    chk("drain", expq.size(), 0);
  endtask

  task automatic idle_start_stop();
    @(posedge clk_sys); #1;
    start = 1'b1; stop = 1'b1; step_period = 16'd1; n_edges = 16'd4;
    @(posedge clk_sys); #1;
    start = 1'b0; stop = 1'b0;
    repeat (4) @(posedge clk_sys);
    #1;
    chk("start_with_stop_busy", busy, 0);
    chk("start_with_stop_cnt", edge_count, last_cnt);
  endtask

  task automatic reset_mid();
    int t0;
    ev_t e;
    @(posedge clk_sys); #1;
    dir = 1'b1; step_period = 16'd2; n_edges = 16'd0; start = 1'b1; stop = 1'b0;
    t0 = cyc;
    for (int j = 1; j <= 3; j++) begin
      mi = (mi + 1) % 4;
      e.is_done = 1'b0; e.cyc = t0 + 2 * j; {e.a, e.b} = seq[mi]; e.ab = 1'b0; e.cnt = j[CW-1:0];
      expq.push_back(e);
    end
    prev_ab = b_ab; b_t1 = t0 + 1; b_done = FAR; b_ab = 1'b0;
    run_lo = t0 + 1; run_hi = FAR;
    @(posedge clk_sys); #1;
    start = 1'b0;
    while (cyc < t0 + 6) begin
      @(posedge clk_sys); #1;
    end
    @(negedge clk_sys); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ab", {a_out, b_out}, 2'b00);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_cnt", edge_count, 0);
    chk("rst_mid_done_ab", {done, aborted}, 2'b00);
    chk("rst_mid_seen", expq.size(), 0);
    expq.delete();
    mi = 0; run_lo = 1; run_hi = 0; b_t1 = 0; b_done = FAR; b_ab = 1'b0; prev_ab = 1'b0;
    last_cnt = '0;
    repeat (3) @(negedge clk_sys);
    #1 rst_n = 1'b1;
    repeat (8) @(posedge clk_sys);
    #1;
    chk("rst_release_quiet", {busy, a_out, b_out, edge_count}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int d, p, n, so, peff;
    bit bs;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("reset_ab", {a_out, b_out}, 2'b00);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_aborted", aborted, 0);
    chk("reset_cnt", edge_count, 0);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;

    burst(1, 4, 8, 0, 0);
    burst(0, 1, 3, 0, 0);
    burst(1, 2, 0, 20, 0);
    burst(1, 0, 2, 0, 1);
    burst(0, 3, 5, 14, 0);
    burst(1, 3, 5, 15, 0);
    burst(0, 3, 6, 7, 0);
    idle_start_stop();
    reset_mid();

    for (int k = 0; k < 30; k++) begin
      d    = int'($urandom_range(0, 1));
      p    = int'($urandom_range(0, 4));
      n    = int'($urandom_range(0, 10));
      peff = (p == 0) ? 1 : p;
      bs   = $urandom_range(0, 1) == 1;
      if (n == 0) so = int'($urandom_range(1, 25));
      else so = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, n * peff + 2)) : 0;
      burst(d[0], p, n, so, bs);
    end

    repeat (3) @(posedge clk_sys);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
